seq_event_logger: RTL
=====================

# seq_event_logger

Downstream consumer of the sequence detector's `sequence_found` pulse. Each accepted detection is timestamped with a free-running cycle counter, tagged with a running event index, and pushed into a small FIFO. The FIFO drains to software or bus logic over a valid/ready interface. Overflow drops are counted so the consumer can detect gaps from missing indices.

## Interface
Parameters:
- `TS_WIDTH`, 16: timestamp counter width.
- `CNT_WIDTH`, 16: event index, total-count and drop-count width.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `IRQ_LEVEL`, 4: FIFO level at or above which `irq` asserts; 1..DEPTH.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when 0, `sequence_found` is ignored.
- `clear` in 1: synchronous flush of FIFO, counters and flags.
- `sequence_found` in 1: detection pulse from the sequence detector.
- `evt_valid` out 1: head entry available.
- `evt_ready` in 1: consumer accepts head entry.
- `evt_timestamp` out TS_WIDTH: head entry timestamp.
- `evt_index` out CNT_WIDTH: head entry event index.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set when any event is dropped.
- `drop_count` out CNT_WIDTH: number of dropped events, saturating.
- `total_count` out CNT_WIDTH: number of detected events (accepted plus dropped), wrapping.
- `irq` out 1: level interrupt (see Configuration).

## Operation
- Reset values: all outputs 0, FIFO empty, timestamp counter 0.
- Timestamp counter `ts` increments every cycle, wraps modulo 2^TS_WIDTH, and is zeroed by `clear`. It does not depend on `enable`.
- Detection event: cycle where `sequence_found && enable && !clear`.
- On a detection event:
  - Candidate entry = {`ts`, `total_count`}, both taken from the current cycle.
  - `total_count` increments (wraps).
  - If the FIFO is not full, or a pop happens in the same cycle: push.
  - Otherwise: drop. Set `overflow`; `drop_count` increments, saturating at all-ones.
- Pop: `evt_valid && evt_ready`. Removes the head entry.
- `evt_timestamp`/`evt_index` show the head entry. They hold stable while `evt_valid && !evt_ready`. Their values are don't-care when empty.
- `clear` has priority over push and pop. It empties the FIFO and zeroes `ts`, `total_count`, `drop_count` and `overflow`.
- `reset_n` low mid-operation: immediate return to reset values, regardless of `clk`.
- Pointer arithmetic: read/write pointers are $clog2(DEPTH)+1 bits; full/empty are decided by the MSB comparison. `level` = wptr − rptr.

## Timing
- `sequence_found` high in cycle N → entry pushed at edge ending N → `evt_valid` high in cycle N+1 (if FIFO was empty).
- Entry timestamp equals `ts` during cycle N.
- Pop in cycle M → next entry (or `evt_valid`=0) visible in cycle M+1.
- Full FIFO with simultaneous push and pop: push is accepted and `level` stays at DEPTH. No drop.
- Empty FIFO with simultaneous detection and `evt_ready`: no pop, since `evt_valid`=0. The entry appears in N+1.
- Back-to-back detections: one entry per cycle, no bubble.
- `level`, `overflow`, `drop_count`, `total_count` are registered and update at the edge ending the causing cycle.

## Configuration
- `SEQ_EVENT_LOGGER_IRQ_EN` defined:
  - `irq` is registered and equals (`level` ≥ IRQ_LEVEL) || `overflow`, evaluated one cycle after the state change.
  - `irq` is cleared by reset, `clear`, or draining below IRQ_LEVEL while `overflow`=0.
- `SEQ_EVENT_LOGGER_IRQ_EN` not defined:
  - `irq` is tied to 0.
  - No comparator logic is present.

## Test plan
- Reset, then single detection at `ts`=5 with `evt_ready`=0:
  - `evt_valid`=1 next cycle.
  - `evt_timestamp`=5, `evt_index`=0, `level`=1.
- DEPTH=8: ten consecutive detections, `evt_ready`=0:
  - `level`=8, `overflow`=1, `drop_count`=2, `total_count`=10.
  - Drain yields indices 0..7, timestamps consecutive.
- Full FIFO, detection and `evt_ready`=1 in the same cycle:
  - No drop, `level` stays 8.
  - New tail index equals the prior `total_count`.
- `enable`=0 with three pulses: no entries, `total_count`=0, `ts` still advancing.
- `clear` asserted with 5 entries and `overflow`=1 in the same cycle as a detection:
  - Next cycle: `level`=0, `overflow`=0, all counts 0, `evt_valid`=0.
- With `SEQ_EVENT_LOGGER_IRQ_EN` and IRQ_LEVEL=4:
  - `irq` rises the cycle after `level` reaches 4.
  - `irq` falls after popping to 3.
  - `reset_n` pulse mid-burst returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/seq_event_logger.sv
// Timestamped event logger: stamps each accepted sequence detection into a small FIFO
// drained over valid/ready. Define SEQ_EVENT_LOGGER_IRQ_EN to build the level/overflow irq.
module seq_event_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int CNT_WIDTH = 16,
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     sequence_found,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_WIDTH-1:0]      evt_timestamp,
    output logic [CNT_WIDTH-1:0]     evt_index,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic [CNT_WIDTH-1:0]     total_count,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (1 << AW) != DEPTH || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_params
        $error("seq_event_logger: DEPTH must be a power of two >= 2 and IRQ_LEVEL in 1..DEPTH");
    end

    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [TS_WIDTH-1:0]  ts;
    logic [TS_WIDTH-1:0]  ts_mem  [DEPTH];
    logic [CNT_WIDTH-1:0] idx_mem [DEPTH];
    logic                 empty;
    logic                 full;
    logic                 detect;
    logic                 pop;
    logic                 push;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign detect = sequence_found && enable && !clear;
    assign pop    = !empty && evt_ready && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push   = detect && (!full || pop);

    assign evt_valid = !empty;
    assign level     = wptr - rptr;

    // Storage is not reset, so mask the head while empty to keep outputs at 0 after reset.
    assign evt_timestamp = empty ? '0 : ts_mem[rptr[AW-1:0]];
    assign evt_index     = empty ? '0 : idx_mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            ts          <= '0;
            total_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            wptr        <= '0;
            rptr        <= '0;
            ts          <= '0;
            total_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (detect) begin
                total_count <= total_count + 1'b1;
                if (!push) begin
                    overflow <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: the entry array has no reset; its contents are never observed while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wptr[AW-1:0]]  <= ts;
            idx_mem[wptr[AW-1:0]] <= total_count;
        end
    end

`ifdef SEQ_EVENT_LOGGER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (clear) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (level >= LW'(IRQ_LEVEL)) || overflow;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
